// File: rtl/puntaje_pkg.sv
// Shared definitions for the score display scanner: game FSM state
// encodings, segment constants and display geometry.
package puntaje_pkg;

   typedef enum logic [2:0] {
      OFF  = 3'd0,
      WLCM = 3'd1,
      CH   = 3'd2,
      GAME = 3'd3,
      WL   = 3'd4,
      PA   = 3'd5
   } game_state_t;

   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned SEG_W      = 7;

   // gfedcba, active-high, as emitted by the score bus
   localparam logic [SEG_W-1:0] SEG_ZERO_PAT = 7'b0111111;
   localparam logic [SEG_W-1:0] SEG_BLANK    = '0;

endpackage

// File: rtl/puntaje_display_scan_tick_divisor.sv
// tick_divisor: modulo-N counter with a terminal-count pulse.
//   clk, rst : clock, synchronous active-high reset
//   clr      : force the count back to 0 (dominates en)
//   en       : advance the count this cycle
//   cnt      : current count, 0..N-1
//   tc       : high on the cycle the counter advances from N-1 back to 0
module tick_divisor #(
   parameter  int unsigned N = 10,
   localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         tc
);

   localparam logic [W-1:0] LAST = W'(N - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en)
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;
   assign tc  = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/puntaje_display_scan.sv
// puntaje_display_scan: time-multiplexes the 4x7 score segment bus onto a
// 4-digit common-anode seven-segment display.
//   clk, rst        : clock, synchronous active-high reset
//   display_puntaje : 4 digits x gfedcba (active-high), [6:0] = rightmost digit
//   presente        : game FSM state (OFF blanks, PA blinks, others normal)
//   lz_enable       : suppress leading zeros
//   seg             : segment drive for the scanned digit (polarity per ACTIVE_LOW)
//   an              : one-hot anode select, an[0] = rightmost digit
//   digit_idx       : digit currently being scanned
module puntaje_display_scan
   import puntaje_pkg::*;
#(
   parameter int unsigned CLK_HZ       = 27000000,
   parameter int unsigned SCAN_HZ      = 1000,
   parameter int unsigned BLANK_CYCLES = 16,
   parameter int unsigned BLINK_HZ     = 2,
   parameter bit          ACTIVE_LOW   = 1'b1,
   parameter logic [6:0]  SEG_ZERO     = SEG_ZERO_PAT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [27:0] display_puntaje,
   input  logic [2:0]  presente,
   input  logic        lz_enable,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic [1:0]  digit_idx
);

   localparam int unsigned SLOT = CLK_HZ / SCAN_HZ;
   localparam int unsigned HALF = CLK_HZ / (2 * BLINK_HZ);
   localparam int unsigned SW   = (SLOT > 1) ? $clog2(SLOT) : 1;
   localparam int unsigned BW   = (HALF > 1) ? $clog2(HALF) : 1;

   logic [SW-1:0] slot_cnt;
   logic          slot_tc;
   logic [BW-1:0] blink_cnt_unused;
   logic          blink_tc;
   logic          in_pa;

   logic [1:0]                       digit_idx_q, digit_idx_d;
   logic [NUM_DIGITS-1:0][SEG_W-1:0] shadow_q, shadow_d;
   logic                             phase_q, phase_d;   // 1 = hidden half of blink
   logic [NUM_DIGITS-1:0]            an_q, an_d;         // active-high internally
   logic [SEG_W-1:0]                 seg_q, seg_d;       // active-high internally
   logic [NUM_DIGITS-1:0]            suppress;
   logic                             show;

   assign in_pa = (presente == PA);

   tick_divisor #(.N(SLOT)) u_slot (
      .clk (clk),
      .rst (rst),
      .clr (1'b0),
      .en  (1'b1),
      .cnt (slot_cnt),
      .tc  (slot_tc)
   );

   // Held at zero outside PA, so every pause starts on a visible half-period.
   tick_divisor #(.N(HALF)) u_blink (
      .clk (clk),
      .rst (rst),
      .clr (!in_pa),
      .en  (in_pa),
      .cnt (blink_cnt_unused),
      .tc  (blink_tc)
   );

   always_comb begin
      digit_idx_d = digit_idx_q;
      shadow_d    = shadow_q;
      phase_d     = phase_q;
      if (slot_tc) begin
         digit_idx_d = digit_idx_q + 2'd1;
         // Capture only at the frame boundary so a frame never mixes two scores.
         if (digit_idx_q == 2'd3)
            shadow_d = display_puntaje;
      end
      if (!in_pa)
         phase_d = 1'b0;
      else if (blink_tc)
         phase_d = !phase_q;
   end

   // A digit is suppressed only while every digit above it is also a blank zero.
   always_comb begin
      suppress    = '0;
      suppress[3] = lz_enable && (shadow_q[3] == SEG_ZERO);
      suppress[2] = suppress[3] && (shadow_q[2] == SEG_ZERO);
      suppress[1] = suppress[2] && (shadow_q[1] == SEG_ZERO);
   end

   always_comb begin
      an_d  = '0;
      seg_d = suppress[digit_idx_q] ? SEG_BLANK : shadow_q[digit_idx_q];
      show  = (slot_cnt >= SW'(BLANK_CYCLES)) && (presente != OFF) && !(in_pa && phase_q);
      if (show)
         an_d[digit_idx_q] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         digit_idx_q <= '0;
         shadow_q    <= '0;
         phase_q     <= 1'b0;
         an_q        <= '0;
         seg_q       <= '0;
      end else begin
         digit_idx_q <= digit_idx_d;
         shadow_q    <= shadow_d;
         phase_q     <= phase_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
      end
   end

   assign an        = ACTIVE_LOW ? ~an_q  : an_q;
   assign seg       = ACTIVE_LOW ? ~seg_q : seg_q;
   assign digit_idx = digit_idx_q;

endmodule

// File: tb/tb_puntaje_display_scan.sv
// Bench for puntaje_display_scan: directed scenarios plus random bus/state
// traffic, checked every cycle against a cycle-count based reference model.
module tb_puntaje_display_scan;
   import puntaje_pkg::*;

   localparam int unsigned SLOT  = 10;
   localparam int unsigned HALF  = 20;
   localparam int unsigned BLANK = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [27:0] bus = '0;
   logic [2:0]  presente = GAME;
   logic        lz = 1'b0;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic [1:0]  digit_idx;

   int checks   = 0;
   int failures = 0;

   // Model state: cycles since reset release, captured frame, length of current pause.
   int unsigned n        = 0;
   logic [27:0] shadow_m = '0;
   int unsigned pa_run   = 0;

   puntaje_display_scan #(
      .CLK_HZ       (1000),
      .SCAN_HZ      (100),
      .BLANK_CYCLES (1),
      .BLINK_HZ     (25),
      .ACTIVE_LOW   (1'b1),
      .SEG_ZERO     (SEG_ZERO_PAT)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .display_puntaje (bus),
      .presente        (presente),
      .lz_enable       (lz),
      .seg             (seg),
      .an              (an),
      .digit_idx       (digit_idx)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] dig(input logic [27:0] b, input int unsigned k);
      case (k)
         0:       return b[6:0];
         1:       return b[13:7];
         2:       return b[20:14];
         default: return b[27:21];
      endcase
   endfunction

   function automatic logic [27:0] rand_bus();
      logic [27:0] b;
      logic [6:0]  d;
      b = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         d = ($urandom_range(0, 1) == 0) ? SEG_ZERO_PAT : 7'($urandom);
         b = {b[20:0], d};
      end
      return b;
   endfunction

   task automatic step();
      int unsigned pos, idx;
      logic [3:0]  an_e;
      logic [6:0]  seg_e;
      logic [1:0]  di_e;
      bit          vis, blanked;
      pos = n % SLOT;
      idx = (n / SLOT) % 4;
      if (rst) begin
         an_e  = 4'hF;
         seg_e = 7'h7F;
      end else begin
         blanked = 1'b0;
         if (lz && idx > 0) begin
            blanked = 1'b1;
            for (int unsigned j = idx; j < 4; j++)
               if (dig(shadow_m, j) != SEG_ZERO_PAT) blanked = 1'b0;
         end
         seg_e = blanked ? 7'h7F : ~dig(shadow_m, idx);
         vis   = (pos >= BLANK) && (presente != OFF) &&
                 !((presente == PA) && (((pa_run / HALF) % 2) == 1));
         an_e  = 4'hF;
         if (vis) an_e[idx[1:0]] = 1'b0;
      end
      @(posedge clk);
      if (rst) begin
         n        = 0;
         shadow_m = '0;
         pa_run   = 0;
      end else begin
         if (pos == SLOT - 1 && idx == 3) shadow_m = bus;
         n++;
         pa_run = (presente == PA) ? pa_run + 1 : 0;
      end
      di_e = 2'((n / SLOT) % 4);
      #1;
      checks++;
      assert (an === an_e) else begin
         failures++;
         $error("FAIL an t=%0t got=%b exp=%b", $time, an, an_e);
      end
      checks++;
      assert (seg === seg_e) else begin
         failures++;
         $error("FAIL seg t=%0t got=%b exp=%b", $time, seg, seg_e);
      end
      checks++;
      assert (digit_idx === di_e) else begin
         failures++;
         $error("FAIL digit_idx t=%0t got=%0d exp=%0d", $time, digit_idx, di_e);
      end
   endtask

   task automatic run(input int unsigned cycles);
      repeat (cycles) step();
   endtask

   // Advance until the model is at the start of the given digit slot (bounded).
   task automatic run_to_digit(input int unsigned k);
      for (int unsigned i = 0; i < 4 * SLOT; i++) begin
         if (((n / SLOT) % 4) == k && (n % SLOT) == 0) break;
         step();
      end
   endtask

   initial begin
      // Reset and basic scan
      rst = 1'b1; presente = GAME; lz = 1'b0; bus = {7'h06, 7'h5B, 7'h4F, 7'h66};
      run(3);
      rst = 1'b0;
      run(90);

      // Tear-free capture: bus changes while digit 1 is on display
      run_to_digit(1);
      bus = rand_bus();
      run(85);

      // Leading zeros
      bus = {SEG_ZERO_PAT, SEG_ZERO_PAT, 7'h06, SEG_ZERO_PAT};
      lz  = 1'b1; run(85);
      lz  = 1'b0; run(45);
      bus = {4{SEG_ZERO_PAT}};
      lz  = 1'b1; run(85);

      // Pause blink, return to game, re-enter pause
      bus = {7'h06, 7'h5B, 7'h4F, 7'h66}; lz = 1'b0;
      presente = PA;   run(100);
      presente = GAME; run(30);
      presente = PA;   run(50);

      // OFF
      presente = OFF; run(45);

      // Reset in the middle of the digit 2 slot
      presente = GAME;
      run_to_digit(2);
      run(4);
      rst = 1'b1; run(1);
      rst = 1'b0; run(50);

      // Random traffic
      for (int unsigned s = 0; s < 30; s++) begin
         bus      = rand_bus();
         presente = 3'($urandom_range(0, 5));
         lz       = 1'($urandom_range(0, 1));
         rst      = ($urandom_range(0, 15) == 0);
         repeat ($urandom_range(1, 60)) begin
            step();
            rst = 1'b0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/puntaje_display_scan.md
Name: puntaje_display_scan

Overview:
Consumer end of the score display bus. Takes the 28-bit score segment bus (4 digits x 7 segments) from the score block and time-multiplexes it onto a 4-digit common-anode seven-segment display. Adds tear-free frame capture, anti-ghost blanking, leading-zero suppression, and state-dependent blanking and blinking driven by the game FSM state. Sits between the score block and the board display pins.

Parameters:
CLK_HZ, 27000000, system clock frequency in Hz
SCAN_HZ, 1000, digit slot rate in Hz; slot length SLOT = CLK_HZ/SCAN_HZ cycles
BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off (anti-ghost); must be < SLOT
BLINK_HZ, 2, pause blink rate; half-period HALF = CLK_HZ/(2*BLINK_HZ) cycles
ACTIVE_LOW, 1, 1 = anodes and segments driven active-low
SEG_ZERO, 7'b0111111, gfedcba active-high pattern for digit '0' as emitted by the score bus

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
display_puntaje  input  28  segment bus, active-high gfedcba per digit; [6:0] = digit0 (rightmost) ... [27:21] = digit3
presente  input  3  game FSM state: OFF=0, WLCM=1, CH=2, GAME=3, WL=4, PA=5
lz_enable  input  1  1 = suppress leading zeros
seg  output  7  segment drive for the selected digit (gfedcba, polarity per ACTIVE_LOW)
an  output  4  anode select, one-hot active, an[0] = digit0
digit_idx  output  2  currently scanned digit (debug/verification)

Behaviour:
- Reset: digit_idx=0, slot counter=0, blink counter=0, blink phase=visible, shadow=0; an all inactive (4'b1111 if ACTIVE_LOW), seg all inactive (7'b1111111 if ACTIVE_LOW). This applies identically when rst is asserted mid-scan.
- Slot counter counts 0..SLOT-1. At SLOT-1, it wraps to 0 and digit_idx advances 0->1->2->3->0.
- Frame capture: on the cycle where the counter wraps and digit_idx goes 3->0, display_puntaje is latched into the shadow register. All digits of a frame come from the same shadow, so mid-frame bus changes never tear the display. The first frame after reset shows the shadow value 0 (all blank) until the first capture.
- Outputs are registered and have 1 cycle of latency from the counter/index state.
- Anti-ghost: while slot counter < BLANK_CYCLES, an is all inactive. seg already carries the new digit pattern during this window.
- Otherwise an = one-hot(digit_idx) and seg = shadow[digit_idx], with the polarity applied.
- Leading-zero suppression (lz_enable=1): digit k (k=3,2,1) is blanked iff its pattern == SEG_ZERO and every higher digit is also blanked. Digit0 is never suppressed. A score of all '0' therefore shows a single '0'.
- State gating:
  - OFF: an all inactive.
  - PA: display visible only during the visible blink phase.
  - All other states: normal display.
- Blink: the blink counter runs only while presente==PA and toggles the phase every HALF cycles. Entering PA from any other state resets the counter and sets the phase to visible, so the first HALF cycles of a pause are shown.
- Simultaneous events: rst has priority over everything. If frame capture and a state change occur in the same cycle, both take effect. A state change takes effect on the next output update, with no wait for a frame boundary.
- Width rules: slot, blank and blink counters are sized by $clog2 of their terminal values. No arithmetic exceeds those widths.

Decomposition:
- Shared package puntaje_pkg holds:
  - game-state localparams OFF..PA (3-bit)
  - SEG_ZERO and blank segment constants
  - digit count (4) and segment width (7)
- One natural sub-module: tick_divisor. It is a parameterised modulo-N counter with a terminal-count pulse, instantiated for the slot timer and the blink timer.

Test Plan:
Use CLK_HZ=1000, SCAN_HZ=100 (SLOT=10), BLANK_CYCLES=1, BLINK_HZ=25 (HALF=20), ACTIVE_LOW=1.
1. Reset/scan: rst for 3 cycles, then release with presente=GAME. Required: an=1111 during reset; after the first capture, an cycles 1110,1101,1011,0111 with each slot showing 1 cycle of 1111 then 9 active cycles; digit_idx wraps 3->0 every 40 cycles.
2. Pattern mapping: bus={7'h06,7'h5B,7'h4F,7'h66}. Required: when an=1110 seg=~7'h66, and when an=0111 seg=~7'h06.
3. Tear-free capture: change the bus mid-frame (digit_idx=1). Required: the remaining digits of that frame still show the old value; the new value appears from the next digit0 slot.
4. Leading zeros: bus={SEG_ZERO,SEG_ZERO,7'h06,SEG_ZERO}, lz_enable=1. Required: digits 3 and 2 blank, digits 1 and 0 lit. With lz_enable=0, all four digits are lit.
5. Pause blink: switch presente GAME->PA. Required: 20 cycles visible, 20 cycles with an=1111, repeating. Returning to GAME gives an immediate normal scan; re-entering PA starts visible again.
6. OFF and mid-scan reset: presente=OFF gives an=1111 continuously. Asserting rst at digit_idx=2 gives digit_idx=0, an=1111 and seg=1111111 on the next cycle.
